// File: rtl/lc3_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_wb_pkg
// Description : Shared types and helpers for the LC3 writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_wb_pkg;

  // Writeback result source select
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_src_e;

  // PSR value out of reset: Z set
  localparam logic [2:0] PSR_RESET = 3'b010;

  // Condition codes {N,Z,P} from the result sign bit and zero flag.
  // Exactly one bit is ever set.
  function automatic logic [2:0] nzp_f(input logic msb, input logic is_zero);
    if (msb) begin
      nzp_f = 3'b100;
    end else if (is_zero) begin
      nzp_f = 3'b010;
    end else begin
      nzp_f = 3'b001;
    end
  endfunction

endpackage : lc3_wb_pkg
`default_nettype wire

// File: rtl/lc3_regfile.sv
`default_nettype none
// ============================================================================
// Module      : lc3_regfile
// Description : NUM_REGS x DATA_WIDTH register file, one synchronous write
//               port, NUM_RD combinational read ports, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RD     = 2,
  parameter int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         we,
  input  logic [REG_AW-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*REG_AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  // Next-state of the array: only the addressed entry changes on a write
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage register with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[g*REG_AW +: REG_AW]];
    end
  endgenerate

endmodule : lc3_regfile
`default_nettype wire

// File: rtl/lc3_writeback_rf.sv
`default_nettype none
// ============================================================================
// Module      : lc3_writeback_rf
// Description : LC3 writeback stage: source mux, one-entry commit stage,
//               register file write, NZP PSR update and read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_writeback_rf
  import lc3_wb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REGS   = 8,
  parameter  int NUM_RD     = 2,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   W_Control,
  input  logic [DATA_WIDTH-1:0]        aluout,
  input  logic [DATA_WIDTH-1:0]        memout,
  input  logic [DATA_WIDTH-1:0]        pcout,
  input  logic [DATA_WIDTH-1:0]        npc,
  input  logic [REG_AW-1:0]            dr,
  input  logic                         psr_en,
  input  logic                         commit_hold,
  input  logic [NUM_RD*REG_AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [2:0]                   psr,
  output logic                         wb_valid,
  output logic [REG_AW-1:0]            wb_dr
);

  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0] wb_value_q, wb_value_d;
  logic [REG_AW-1:0]     wb_dr_q,    wb_dr_d;
  logic                  wb_psr_en_q, wb_psr_en_d;
  logic [2:0]            psr_q,      psr_d;

  logic                  accept;
  logic                  commit;
  logic [DATA_WIDTH-1:0] src_value;
  logic [NUM_RD*DATA_WIDTH-1:0] rf_rd_data;

  // Stage frees up when empty or when it is about to drain; in_valid is not involved
  assign in_ready = !wb_valid_q || !commit_hold;
  assign accept   = in_valid && in_ready;
  assign commit   = wb_valid_q && !commit_hold;

  // Result source select
  always_comb begin
    src_value = aluout;
    case (W_Control)
      WB_ALU:  src_value = aluout;
      WB_MEM:  src_value = memout;
      WB_PC:   src_value = pcout;
      WB_NPC:  src_value = npc;
      default: src_value = aluout;
    endcase
  end

  // Commit-stage and PSR next state: a new capture takes priority over draining
  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_value_d  = wb_value_q;
    wb_dr_d     = wb_dr_q;
    wb_psr_en_d = wb_psr_en_q;
    psr_d       = psr_q;
    if (commit) begin
      wb_valid_d = 1'b0;
      if (wb_psr_en_q) begin
        psr_d = nzp_f(wb_value_q[DATA_WIDTH-1], wb_value_q == '0);
      end
    end
    if (accept) begin
      wb_valid_d  = 1'b1;
      wb_value_d  = src_value;
      wb_dr_d     = dr;
      wb_psr_en_d = psr_en;
    end
  end

  // Commit-stage and PSR registers; reset discards any pending commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q  <= 1'b0;
      wb_value_q  <= '0;
      wb_dr_q     <= '0;
      wb_psr_en_q <= 1'b0;
      psr_q       <= PSR_RESET;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_value_q  <= wb_value_d;
      wb_dr_q     <= wb_dr_d;
      wb_psr_en_q <= wb_psr_en_d;
      psr_q       <= psr_d;
    end
  end

  lc3_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .NUM_RD     (NUM_RD),
    .REG_AW     (REG_AW)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (commit),
    .waddr   (wb_dr_q),
    .wdata   (wb_value_q),
    .rd_addr (rd_addr),
    .rd_data (rf_rd_data)
  );

  // Pending commit value bypasses the array so readers never see stale data
  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_fwd
      assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] =
        (wb_valid_q && (rd_addr[g*REG_AW +: REG_AW] == wb_dr_q)) ?
          wb_value_q : rf_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign psr      = psr_q;
  assign wb_valid = wb_valid_q;
  assign wb_dr    = wb_dr_q;

endmodule : lc3_writeback_rf
`default_nettype wire

// File: tb/tb_lc3_writeback_rf.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_writeback_rf
// Description : Directed self-checking bench for lc3_writeback_rf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_writeback_rf;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  W_Control;
  logic [15:0] aluout, memout, pcout, npc;
  logic [2:0]  dr;
  logic        psr_en;
  logic        commit_hold;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [2:0]  psr;
  logic        wb_valid;
  logic [2:0]  wb_dr;

  int vectors  = 0;
  int failures = 0;

  lc3_writeback_rf #(
    .DATA_WIDTH (16),
    .NUM_REGS   (8),
    .NUM_RD     (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .W_Control   (W_Control),
    .aluout      (aluout),
    .memout      (memout),
    .pcout       (pcout),
    .npc         (npc),
    .dr          (dr),
    .psr_en      (psr_en),
    .commit_hold (commit_hold),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .psr         (psr),
    .wb_valid    (wb_valid),
    .wb_dr       (wb_dr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic req(input logic [1:0] wc, input logic [15:0] val,
                     input logic [2:0] d, input logic pe);
    in_valid  = 1'b1;
    W_Control = wc;
    aluout    = 16'h1111;
    memout    = 16'h2222;
    pcout     = 16'h3333;
    npc       = 16'h4444;
    case (wc)
      2'd0: aluout = val;
      2'd1: memout = val;
      2'd2: pcout  = val;
      default: npc = val;
    endcase
    dr     = d;
    psr_en = pe;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; W_Control = 2'd0;
    aluout = '0; memout = '0; pcout = '0; npc = '0;
    dr = '0; psr_en = 1'b0; commit_hold = 1'b0; rd_addr = '0;
    tick(); tick();

    // Reset state
    check("rst_psr", {13'd0, psr}, 16'h0002);
    check("rst_wb_valid", {15'd0, wb_valid}, 16'h0000);
    check("rst_in_ready", {15'd0, in_ready}, 16'h0001);
    for (int r = 0; r < 8; r++) begin
      set_rd(3'(r), 3'(7 - r));
      check("rst_rd0", rd_data[15:0], 16'h0000);
      check("rst_rd1", rd_data[31:16], 16'h0000);
    end
    reset_n = 1'b1;
    tick();

    // ALU, dr=3, psr_en: forwarded next cycle, committed one cycle later
    req(2'd0, 16'h8001, 3'd3, 1'b1);
    set_rd(3'd3, 3'd3);
    tick();
    in_valid = 1'b0;
    check("alu_wb_valid", {15'd0, wb_valid}, 16'h0001);
    check("alu_wb_dr", {13'd0, wb_dr}, 16'h0003);
    check("alu_fwd", rd_data[15:0], 16'h8001);
    check("alu_psr_pre", {13'd0, psr}, 16'h0002);
    tick();
    check("alu_rf", rd_data[31:16], 16'h8001);
    check("alu_psr", {13'd0, psr}, 16'h0004);
    check("alu_wb_empty", {15'd0, wb_valid}, 16'h0000);

    // NPC, dr=7, no PSR update
    req(2'd3, 16'h3001, 3'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    set_rd(3'd7, 3'd3);
    check("npc_r7", rd_data[15:0], 16'h3001);
    check("npc_r3", rd_data[31:16], 16'h8001);
    check("npc_psr", {13'd0, psr}, 16'h0004);

    // MEM, dr=1, positive result
    req(2'd1, 16'h7FFF, 3'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    set_rd(3'd1, 3'd1);
    check("mem_r1", rd_data[15:0], 16'h7FFF);
    check("mem_psr", {13'd0, psr}, 16'h0001);

    // PC, dr=5, no PSR update
    req(2'd2, 16'h1234, 3'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    set_rd(3'd5, 3'd1);
    check("pc_r5", rd_data[15:0], 16'h1234);
    check("pc_psr", {13'd0, psr}, 16'h0001);

    // Hold with stage loaded: everything frozen, queued request waits
    req(2'd0, 16'h8AAA, 3'd6, 1'b1);
    tick();
    commit_hold = 1'b1;
    req(2'd0, 16'h0BBB, 3'd0, 1'b0);
    set_rd(3'd6, 3'd0);
    for (int c = 0; c < 5; c++) begin
      check("hold_in_ready", {15'd0, in_ready}, 16'h0000);
      check("hold_wb_valid", {15'd0, wb_valid}, 16'h0001);
      check("hold_wb_dr", {13'd0, wb_dr}, 16'h0006);
      check("hold_psr", {13'd0, psr}, 16'h0001);
      check("hold_r0", rd_data[31:16], 16'h0000);
      tick();
    end
    commit_hold = 1'b0;
    #1;
    check("release_in_ready", {15'd0, in_ready}, 16'h0001);
    tick();
    in_valid = 1'b0;
    check("release_r6", rd_data[15:0], 16'h8AAA);
    check("release_psr", {13'd0, psr}, 16'h0004);
    check("release_wb_dr", {13'd0, wb_dr}, 16'h0000);
    check("release_fwd_r0", rd_data[31:16], 16'h0BBB);
    tick();
    check("release_r0", rd_data[31:16], 16'h0BBB);
    check("release_psr2", {13'd0, psr}, 16'h0004);
    check("release_empty", {15'd0, wb_valid}, 16'h0000);

    // Back-to-back writes to dr=2
    set_rd(3'd2, 3'd2);
    req(2'd0, 16'h0000, 3'd2, 1'b1);
    tick();
    check("b2b_fwd0_p0", rd_data[15:0], 16'h0000);
    check("b2b_fwd0_p1", rd_data[31:16], 16'h0000);
    req(2'd0, 16'h0005, 3'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    check("b2b_fwd1_p0", rd_data[15:0], 16'h0005);
    check("b2b_fwd1_p1", rd_data[31:16], 16'h0005);
    check("b2b_psr_mid", {13'd0, psr}, 16'h0002);
    check("b2b_wb_valid", {15'd0, wb_valid}, 16'h0001);
    tick();
    check("b2b_r2_p0", rd_data[15:0], 16'h0005);
    check("b2b_r2_p1", rd_data[31:16], 16'h0005);
    check("b2b_psr", {13'd0, psr}, 16'h0001);

    // Hold with empty stage still accepts; then async reset discards it
    commit_hold = 1'b1;
    #1;
    check("hold_empty_ready", {15'd0, in_ready}, 16'h0001);
    req(2'd0, 16'hBEEF, 3'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    check("beef_wb_valid", {15'd0, wb_valid}, 16'h0001);
    check("beef_in_ready", {15'd0, in_ready}, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_psr", {13'd0, psr}, 16'h0002);
    check("arst_wb_valid", {15'd0, wb_valid}, 16'h0000);
    check("arst_wb_dr", {13'd0, wb_dr}, 16'h0000);
    set_rd(3'd4, 3'd2);
    check("arst_r4", rd_data[15:0], 16'h0000);
    check("arst_r2", rd_data[31:16], 16'h0000);
    commit_hold = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_r4", rd_data[15:0], 16'h0000);
    check("post_psr", {13'd0, psr}, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lc3_writeback_rf
`default_nettype wire
